uart_tx_buffered: RTL

UART transmit path: takes parallel words from the main system through a one-word holding buffer and sends them serially as start bit, data bits LSB first, optional parity, and stop bit. It mirrors the receive-side interface circuit. The buffer flag blocks overwrites and gives the system one word of slack while a frame is on the line. The block sits between the main system (50 MHz `clock`) and the shared baud-rate generator, which supplies the `s_tick` oversampling pulse.

---
 rtl/uart_pkg.sv | 17 +
 rtl/tx_hold_reg.sv | 43 ++++
 rtl/uart_tx_buffered.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default tick counts, idle line level.
// Used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned OS_TICK_DEF = 16;
    localparam int unsigned SB_TICK_DEF = 16;
    localparam logic        LINE_IDLE   = 1'b1;

endpackage

// File: rtl/tx_hold_reg.sv
// One-word transmit holding buffer: captures a word when empty, ignores writes while full,
// and is emptied when the transmit FSM takes the word.
module tx_hold_reg #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr,
    input  logic                 take,
    input  logic [DATA_BITS-1:0] w_data,
    output logic [DATA_BITS-1:0] hold_data,
    output logic                 full
);

    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic                 full_q, full_d;

    // take only occurs while full, so it never collides with an accepted write
    always_comb begin
        buf_d  = buf_q;
        full_d = full_q;
        if (take) begin
            full_d = 1'b0;
        end else if (wr && !full_q) begin
            buf_d  = w_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_q  <= '0;
            full_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            full_q <= full_d;
        end
    end

    assign hold_data = buf_q;
    assign full      = full_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: holding register feeding a start/data/stop serialiser.
// Define UART_TX_PARITY_EN to insert an even parity bit after the data bits.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned OS_TICK   = OS_TICK_DEF,
    parameter int unsigned SB_TICK   = SB_TICK_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 wr_tx,
    input  logic [DATA_BITS-1:0] w_data,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic                 tx_done_tick,
    output logic                 tx
);

    localparam int unsigned TMAX = (SB_TICK > OS_TICK) ? SB_TICK : OS_TICK;
    localparam int unsigned CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned NW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] OS_LAST = CW'(OS_TICK - 1);
    localparam logic [CW-1:0] SB_LAST = CW'(SB_TICK - 1);
    localparam logic [NW-1:0] NB_LAST = NW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        s_cnt_q, s_cnt_d;
    logic [NW-1:0]        n_cnt_q, n_cnt_d;
    logic [DATA_BITS-1:0] b_reg_q, b_reg_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 take;
    logic [DATA_BITS-1:0] hold_data;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    tx_hold_reg #(
        .DATA_BITS (DATA_BITS)
    ) u_hold (
        .clock     (clock),
        .reset     (reset),
        .wr        (wr_tx),
        .take      (take),
        .w_data    (w_data),
        .hold_data (hold_data),
        .full      (tx_full)
    );

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_reg_d = b_reg_q;
        done_d  = 1'b0;
        take    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tx_full) begin
                    take    = 1'b1;
                    b_reg_d = hold_data;
                    s_cnt_d = '0;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^hold_data;
`endif
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_cnt_q == OS_LAST) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + CW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == OS_LAST) begin
                        b_reg_d = b_reg_q >> 1;
                        s_cnt_d = '0;
                        if (n_cnt_q == NB_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + CW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == OS_LAST) begin
                        s_cnt_d = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + CW'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == SB_LAST) begin
                        done_d  = 1'b1;
                        s_cnt_d = '0;
                        // a waiting word starts immediately, with no idle bit in between
                        if (tx_full) begin
                            take    = 1'b1;
                            b_reg_d = hold_data;
                            state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                            parity_d = ^hold_data;
`endif
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // line level is registered from the next state so tx has no combinational path
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = b_reg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_reg_q <= '0;
            tx_q    <= LINE_IDLE;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_reg_q <= b_reg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign tx_busy      = (state_q != ST_IDLE);

endmodule
